tt_decoder_pipe: RTL and testbench

//  Multi-lane, registered binary-to-mask decoder with valid/ready flow control.

---
 rtl/tt_decoder_pkg.sv | 16 +
 rtl/tt_decoder_lane.sv | 43 ++++
 rtl/tt_decoder_pipe.sv | 141 ++++++++++++++
 tb/tb_tt_decoder_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_decoder_pkg.sv
// tt_decoder_pkg: shared types for the tt_decoder_pipe mask decoder.
//   decode_mode_e selects how a lane index is turned into a mask:
//     DEC_ONEHOT    single bit at the index
//     DEC_THERMO_LO bits at and below the index
//     DEC_THERMO_HI bits at and above the index
//     DEC_RSVD      reserved; every enabled lane reports an error
package tt_decoder_pkg;

    typedef enum logic [1:0] {
        DEC_ONEHOT,
        DEC_THERMO_LO,
        DEC_THERMO_HI,
        DEC_RSVD
    } decode_mode_e;

endpackage

// File: rtl/tt_decoder_lane.sv
// tt_decoder_lane: combinational decode of one lane index into a mask.
//   i_idx   encoded index
//   i_mode  decode mode
//   i_en    lane enable; a disabled lane gives an all-zero mask and no error
//   o_mask  decoded mask (zero on error or when disabled)
//   o_err   lane enabled and index out of range or mode reserved
module tt_decoder_lane
    import tt_decoder_pkg::*;
#(
    parameter int DECODED_WIDTH = 32,
    parameter int ENCODED_WIDTH = $clog2(DECODED_WIDTH)
) (
    input  logic [ENCODED_WIDTH-1:0] i_idx,
    input  decode_mode_e             i_mode,
    input  logic                     i_en,
    output logic [DECODED_WIDTH-1:0] o_mask,
    output logic                     o_err
);

    // A power-of-two width means every encodable index is in range.
    localparam bit POW2 = (DECODED_WIDTH == (1 << ENCODED_WIDTH));

    logic                     w_oor;
    logic [DECODED_WIDTH-1:0] w_raw;

    assign w_oor = POW2 ? 1'b0 : (32'(i_idx) >= 32'(DECODED_WIDTH));

    for (genvar j = 0; j < DECODED_WIDTH; j++) begin : g_bit
        localparam logic [ENCODED_WIDTH-1:0] J = ENCODED_WIDTH'(j);
        assign w_raw[j] = (i_mode == DEC_ONEHOT)    ? (J == i_idx) :
                          (i_mode == DEC_THERMO_LO) ? (J <= i_idx) :
                                                      (J >= i_idx);
    end

    assign o_err  = i_en & (w_oor | (i_mode == DEC_RSVD));
    assign o_mask = (i_en & ~o_err) ? w_raw : '0;

    always_comb begin
        if (i_en && !o_err && i_mode == DEC_ONEHOT)
            a_onehot: assert ($onehot(o_mask)) else $error("onehot lane mask not onehot");
    end

endmodule

// File: rtl/tt_decoder_pipe.sv
// tt_decoder_pipe: multi-lane registered index-to-mask decoder with a 2-entry skid.
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_valid/o_ready  input handshake; o_ready is registered (= skid entry empty)
//   i_mode           decode mode (decode_mode_e encoding)
//   i_lane_en        per-lane enable
//   i_encoded        lane k index at [k*EW +: EW]
//   o_valid/i_ready  output handshake
//   o_decoded        lane k mask at [k*DW +: DW]
//   o_err_lane       per-lane error of the presented output
//   i_err_clr        clear error counter and sticky flag
//   o_err_cnt        saturating count of accepted transactions with any lane error
//   o_err_sticky     set by any accepted transaction with a lane error
module tt_decoder_pipe
    import tt_decoder_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int DECODED_WIDTH = 32,
    parameter int ERR_CNT_WIDTH = 8,
    localparam int ENCODED_WIDTH = $clog2(DECODED_WIDTH)
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [1:0]                       i_mode,
    input  logic [LANES-1:0]                 i_lane_en,
    input  logic [LANES*ENCODED_WIDTH-1:0]   i_encoded,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [LANES*DECODED_WIDTH-1:0]   o_decoded,
    output logic [LANES-1:0]                 o_err_lane,
    input  logic                             i_err_clr,
    output logic [ERR_CNT_WIDTH-1:0]         o_err_cnt,
    output logic                             o_err_sticky
);

    localparam int DW_ALL = LANES * DECODED_WIDTH;

    decode_mode_e             w_mode;
    logic [DW_ALL-1:0]        w_dec;
    logic [LANES-1:0]         w_err;
    logic                     w_accept;
    logic                     w_out_load;
    logic                     w_skid_valid_nxt;
    logic                     w_event;

    logic                     r_ready;
    logic                     r_out_valid;
    logic [DW_ALL-1:0]        r_out_dec;
    logic [LANES-1:0]         r_out_err;
    logic                     r_skid_valid;
    logic [DW_ALL-1:0]        r_skid_dec;
    logic [LANES-1:0]         r_skid_err;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic                     r_err_sticky;

    assign w_mode = decode_mode_e'(i_mode);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        tt_decoder_lane #(
            .DECODED_WIDTH (DECODED_WIDTH),
            .ENCODED_WIDTH (ENCODED_WIDTH)
        ) u_lane (
            .i_idx  (i_encoded[k*ENCODED_WIDTH +: ENCODED_WIDTH]),
            .i_mode (w_mode),
            .i_en   (i_lane_en[k]),
            .o_mask (w_dec[k*DECODED_WIDTH +: DECODED_WIDTH]),
            .o_err  (w_err[k])
        );
    end

    assign w_accept   = i_valid & r_ready;
    // Output register can take new data when it is empty or being handed off.
    assign w_out_load = ~r_out_valid | i_ready;
    // A held skid entry leaves only when the output register loads; an accept
    // lands in the skid only when the output register is stalled.
    assign w_skid_valid_nxt = r_skid_valid ? ~w_out_load : (w_accept & ~w_out_load);
    assign w_event    = w_accept & (|w_err);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ready      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_dec    <= '0;
            r_out_err    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_dec   <= '0;
            r_skid_err   <= '0;
        end else begin
            r_ready      <= ~w_skid_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_out_load) begin
                // o_ready is low while the skid is full, so no accept competes here.
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_dec   <= r_skid_dec;
                    r_out_err   <= r_skid_err;
                end else begin
                    r_out_valid <= w_accept;
                    if (w_accept) begin
                        r_out_dec <= w_dec;
                        r_out_err <= w_err;
                    end
                end
            end else if (w_accept) begin
                r_skid_dec <= w_dec;
                r_skid_err <= w_err;
            end
        end
    end

    // Clear wins over history but not over a same-cycle event.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (i_err_clr) begin
            r_err_cnt    <= ERR_CNT_WIDTH'(w_event);
            r_err_sticky <= w_event;
        end else if (w_event) begin
            r_err_cnt    <= (&r_err_cnt) ? r_err_cnt : r_err_cnt + 1'b1;
            r_err_sticky <= 1'b1;
        end
    end

    assign o_ready      = r_ready;
    assign o_valid      = r_out_valid;
    assign o_decoded    = r_out_dec;
    assign o_err_lane   = r_out_err;
    assign o_err_cnt    = r_err_cnt;
    assign o_err_sticky = r_err_sticky;

    a_stall_stable: assert property (@(posedge i_clk) disable iff (i_reset)
        (r_out_valid && !i_ready) |=> ($stable(r_out_dec) && $stable(r_out_err)))
        else $error("output changed while stalled");

    a_no_accept_when_full: assert property (@(posedge i_clk) disable iff (i_reset)
        !r_ready |=> $stable(r_skid_dec))
        else $error("skid written while not ready");

endmodule

// File: tb/tb_tt_decoder_pipe.sv
module tb_tt_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid, i_ready, i_err_clr;
    logic [1:0]  i_mode;
    logic [3:0]  i_lane_en;
    logic [19:0] i_encoded;

    logic         o_ready_a, o_valid_a, o_sticky_a;
    logic [127:0] o_dec_a;
    logic [3:0]   o_err_a;
    logic [7:0]   o_cnt_a;
    logic         o_ready_b, o_valid_b, o_sticky_b;
    logic [79:0]  o_dec_b;
    logic [3:0]   o_err_b;
    logic [1:0]   o_cnt_b;

    always #5 clk = ~clk;

    tt_decoder_pipe u_a (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready_a),
        .i_mode(i_mode), .i_lane_en(i_lane_en), .i_encoded(i_encoded),
        .o_valid(o_valid_a), .i_ready(i_ready), .o_decoded(o_dec_a),
        .o_err_lane(o_err_a), .i_err_clr(i_err_clr), .o_err_cnt(o_cnt_a),
        .o_err_sticky(o_sticky_a)
    );

    tt_decoder_pipe #(.DECODED_WIDTH(20), .ERR_CNT_WIDTH(2)) u_b (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready_b),
        .i_mode(i_mode), .i_lane_en(i_lane_en), .i_encoded(i_encoded),
        .o_valid(o_valid_b), .i_ready(i_ready), .o_decoded(o_dec_b),
        .o_err_lane(o_err_b), .i_err_clr(i_err_clr), .o_err_cnt(o_cnt_b),
        .o_err_sticky(o_sticky_b)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  en;
        logic [19:0] enc;
    } txn_t;

    txn_t q[$];
    bit   m_ready = 1'b0;
    int   cnt_a = 0, cnt_b = 0;
    bit   st_a = 1'b0, st_b = 1'b0;
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_err(input txn_t t, input int dw);
        logic [3:0] e;
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx  = int'(t.enc[k*5 +: 5]);
            e[k] = t.en[k] && (idx >= dw || t.mode == 2'd3);
        end
        return e;
    endfunction

    function automatic logic [127:0] exp_dec(input txn_t t, input int dw);
        logic [127:0] r;
        logic [3:0]   e;
        logic [63:0]  full, m;
        int           idx;
        r    = '0;
        e    = exp_err(t, dw);
        full = (64'd1 << dw) - 64'd1;
        for (int k = 0; k < 4; k++) begin
            idx = int'(t.enc[k*5 +: 5]);
            if (t.en[k] && !e[k]) begin
                m = (t.mode == 2'd0) ? (64'd1 << idx) :
                    (t.mode == 2'd1) ? ((64'd2 << idx) - 64'd1) :
                                       (full & ~((64'd1 << idx) - 64'd1));
                r = r | (128'(m & full) << (k * dw));
            end
        end
        return r;
    endfunction

    // Transaction-level model plus per-cycle comparison against both instances.
    initial begin
        txn_t t;
        bit   acc, ev_a, ev_b;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_ready = 1'b0;
                cnt_a = 0; cnt_b = 0; st_a = 1'b0; st_b = 1'b0;
            end else begin
                acc    = i_valid && m_ready;
                t.mode = i_mode; t.en = i_lane_en; t.enc = i_encoded;
                ev_a   = acc && (exp_err(t, 32) != 4'd0);
                ev_b   = acc && (exp_err(t, 20) != 4'd0);
                if (i_err_clr) begin
                    cnt_a = ev_a ? 1 : 0; st_a = ev_a;
                    cnt_b = ev_b ? 1 : 0; st_b = ev_b;
                end else begin
                    if (ev_a) begin cnt_a = (cnt_a == 255) ? 255 : cnt_a + 1; st_a = 1'b1; end
                    if (ev_b) begin cnt_b = (cnt_b == 3) ? 3 : cnt_b + 1; st_b = 1'b1; end
                end
                if (q.size() > 0 && i_ready) void'(q.pop_front());
                if (acc) q.push_back(t);
                m_ready = (q.size() < 2);
            end
            #2;
            chk("m_ready_a", 128'(o_ready_a), 128'(m_ready));
            chk("m_ready_b", 128'(o_ready_b), 128'(m_ready));
            chk("m_valid_a", 128'(o_valid_a), 128'(q.size() > 0));
            chk("m_valid_b", 128'(o_valid_b), 128'(q.size() > 0));
            chk("m_cnt_a", 128'(o_cnt_a), 128'(cnt_a));
            chk("m_cnt_b", 128'(o_cnt_b), 128'(cnt_b));
            chk("m_sticky_a", 128'(o_sticky_a), 128'(st_a));
            chk("m_sticky_b", 128'(o_sticky_b), 128'(st_b));
            if (q.size() > 0) begin
                chk("m_dec_a", o_dec_a, exp_dec(q[0], 32));
                chk("m_dec_b", 128'(o_dec_b), exp_dec(q[0], 20));
                chk("m_err_a", 128'(o_err_a), 128'(exp_err(q[0], 32)));
                chk("m_err_b", 128'(o_err_b), 128'(exp_err(q[0], 20)));
            end
        end
    end

    function automatic logic [19:0] enc4(input int l0, input int l1, input int l2, input int l3);
        return {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
    endfunction

    task automatic cyc(input logic v, input logic [1:0] m, input logic [3:0] en,
                       input logic [19:0] enc, input logic rdy, input logic clr);
        @(negedge clk);
        i_valid = v; i_mode = m; i_lane_en = en; i_encoded = enc;
        i_ready = rdy; i_err_clr = clr;
    endtask

    task automatic post();
        @(posedge clk);
        #3;
    endtask

    initial begin
        i_valid = 1'b0; i_mode = 2'd0; i_lane_en = 4'hF; i_encoded = '0;
        i_ready = 1'b1; i_err_clr = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(o_ready_a), 128'd0);
        chk("rst_valid", 128'(o_valid_a), 128'd0);
        chk("rst_dec", o_dec_a, 128'd0);
        chk("rst_err", 128'(o_err_a), 128'd0);
        chk("rst_cnt", 128'(o_cnt_a), 128'd0);
        rst = 1'b0;
        post();
        chk("rel_ready", 128'(o_ready_a), 128'd1);

        cyc(1, 2'd0, 4'hF, enc4(0, 5, 31, 17), 1, 0);
        post();
        chk("t1_valid", 128'(o_valid_a), 128'd1);
        chk("t1_dec", o_dec_a, {32'h0002_0000, 32'h8000_0000, 32'h0000_0020, 32'h0000_0001});
        chk("t1_err", 128'(o_err_a), 128'd0);
        chk("t1_err_b", 128'(o_err_b), 128'h4);

        cyc(1, 2'd1, 4'hF, enc4(3, 0, 19, 31), 1, 0);
        post();
        chk("t2_lo", o_dec_a, {32'hFFFF_FFFF, 32'h000F_FFFF, 32'h0000_0001, 32'h0000_000F});
        cyc(1, 2'd2, 4'b1011, enc4(30, 0, 31, 1), 1, 0);
        post();
        chk("t2_hi", o_dec_a, {32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hC000_0000});
        chk("t2_hi_err", 128'(o_err_a), 128'd0);
        chk("t2_hi_err_b", 128'(o_err_b), 128'h1);

        cyc(0, 2'd0, 4'hF, 20'd0, 1, 1);
        post();
        chk("clr_cnt_b", 128'(o_cnt_b), 128'd0);
        chk("clr_sticky_b", 128'(o_sticky_b), 128'd0);

        cyc(1, 2'd0, 4'hF, enc4(0, 25, 3, 4), 1, 0);
        post();
        chk("t3_err_b", 128'(o_err_b), 128'h2);
        chk("t3_lane1_b", 128'(o_dec_b[39:20]), 128'd0);
        chk("t3_cnt_b", 128'(o_cnt_b), 128'd1);
        chk("t3_sticky_b", 128'(o_sticky_b), 128'd1);
        chk("t3_cnt_a", 128'(o_cnt_a), 128'd0);
        cyc(1, 2'd3, 4'hF, enc4(1, 2, 3, 4), 1, 0);
        post();
        chk("t3_rsvd_err", 128'(o_err_a), 128'hF);
        chk("t3_rsvd_dec", o_dec_a, 128'd0);
        chk("t3_rsvd_cnt_a", 128'(o_cnt_a), 128'd1);
        chk("t3_rsvd_cnt_b", 128'(o_cnt_b), 128'd2);

        repeat (5) cyc(1, 2'd3, 4'hF, enc4(1, 2, 3, 4), 1, 0);
        post();
        chk("t5_sat_b", 128'(o_cnt_b), 128'd3);
        chk("t5_cnt_a", 128'(o_cnt_a), 128'd6);
        cyc(1, 2'd3, 4'hF, enc4(1, 2, 3, 4), 1, 1);
        post();
        chk("t5_clr_ev_a", 128'(o_cnt_a), 128'd1);
        chk("t5_clr_ev_b", 128'(o_cnt_b), 128'd1);
        chk("t5_clr_st_b", 128'(o_sticky_b), 128'd1);
        cyc(0, 2'd0, 4'hF, 20'd0, 1, 0);

        cyc(1, 2'd0, 4'hF, enc4(1, 1, 1, 1), 0, 0);
        cyc(1, 2'd0, 4'hF, enc4(2, 2, 2, 2), 0, 0);
        cyc(1, 2'd0, 4'hF, enc4(3, 3, 3, 3), 0, 0);
        post();
        chk("t4_full_ready", 128'(o_ready_a), 128'd0);
        chk("t4_hold1", 128'(o_dec_a[31:0]), 128'h2);
        cyc(1, 2'd0, 4'hF, enc4(3, 3, 3, 3), 1, 0);
        post();
        chk("t4_drain2", 128'(o_dec_a[31:0]), 128'h4);
        cyc(1, 2'd0, 4'hF, enc4(3, 3, 3, 3), 1, 0);
        post();
        chk("t4_drain3", 128'(o_dec_a[31:0]), 128'h8);
        cyc(0, 2'd0, 4'hF, 20'd0, 1, 0);

        cyc(1, 2'd3, 4'hF, enc4(1, 2, 3, 4), 0, 0);
        cyc(1, 2'd3, 4'hF, enc4(5, 6, 7, 8), 0, 0);
        post();
        chk("t6_full_valid", 128'(o_valid_a), 128'd1);
        chk("t6_full_ready", 128'(o_ready_a), 128'd0);
        chk("t6_full_cnt", 128'(o_cnt_a), 128'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 128'(o_valid_a), 128'd0);
        chk("t6_rst_ready", 128'(o_ready_a), 128'd0);
        chk("t6_rst_cnt", 128'(o_cnt_a), 128'd0);
        chk("t6_rst_valid_b", 128'(o_valid_b), 128'd0);
        @(negedge clk);
        rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        post();
        chk("t6_rel_ready", 128'(o_ready_a), 128'd1);
        chk("t6_rel_valid", 128'(o_valid_a), 128'd0);
        cyc(1, 2'd1, 4'hF, enc4(4, 4, 4, 4), 1, 0);
        post();
        chk("t6_new_valid", 128'(o_valid_a), 128'd1);
        chk("t6_new_dec", 128'(o_dec_a[31:0]), 128'h1F);
        cyc(0, 2'd0, 4'hF, 20'd0, 1, 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
